// File: rtl/set_assoc_cache_if.sv
// Core-side request/response and AXI-master handshake signals of set_assoc_cache.
// The cache uses the slave modport; the core and AXI master side uses the master modport.
interface set_assoc_cache_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;

    logic              axi_rd_rq;
    logic [ADDR_W-1:0] axi_rd_addr;
    logic              axi_rd_rq_ack;
    logic [DATA_W-1:0] axi_rd_data;
    logic              axi_rd_valid;
    logic              axi_rd_valid_ack;
    logic              axi_wr_rq;
    logic [ADDR_W-1:0] axi_wr_addr;
    logic [DATA_W-1:0] axi_wr_data;
    logic              axi_wr_rq_ack;
    logic              axi_wr_done;
    logic              axi_wr_done_ack;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  axi_rd_rq_ack, axi_rd_data, axi_rd_valid, axi_wr_rq_ack, axi_wr_done,
        output rd_data, rd_valid, wr_done,
        output axi_rd_rq, axi_rd_addr, axi_rd_valid_ack,
        output axi_wr_rq, axi_wr_addr, axi_wr_data, axi_wr_done_ack
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output axi_rd_rq_ack, axi_rd_data, axi_rd_valid, axi_wr_rq_ack, axi_wr_done,
        input  rd_data, rd_valid, wr_done,
        input  axi_rd_rq, axi_rd_addr, axi_rd_valid_ack,
        input  axi_wr_rq, axi_wr_addr, axi_wr_data, axi_wr_done_ack
    );
endinterface

// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-through, no-write-allocate word cache with round-robin replacement.
// Optional read hit/miss counters are built when the macro CACHE_STATS_EN is defined.
module set_assoc_cache #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_WAYS = 2,
    parameter int NUM_SETS = 64
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    set_assoc_cache_if.slave  bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, RESP, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [TAG_W-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
    logic [DATA_W-1:0]   data_mem [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
    logic [WAY_W-1:0]    rr_q     [NUM_SETS];

    logic              is_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_data_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] line_addr;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              found_free;
    logic [WAY_W-1:0]  victim;
    logic [WAY_W-1:0]  rr_nxt;
    logic              fill_en;
    logic              wr_hit_en;

    assign idx       = addr_q[2 +: IDX_W];
    assign tag       = addr_q[ADDR_W-1 -: TAG_W];
    assign line_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign fill_en   = (state == RD_WAIT) && bus.axi_rd_valid;
    assign wr_hit_en = (state == LOOKUP) && is_wr_q && hit;
    assign rr_nxt    = (rr_q[idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;

    // Lowest-index matching way wins; tags are unique per set so at most one matches.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[idx][w] && (tag_mem[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        found_free = 1'b0;
        victim     = rr_q[idx];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found_free && !valid_q[idx][w]) begin
                found_free = 1'b1;
                victim     = WAY_W'(w);
            end
        end
    end

    // Line storage carries no reset; the valid bits alone decide residency.
    always_ff @(posedge i_clk) begin
        if (fill_en) begin
            tag_mem[idx][victim]  <= tag;
            data_mem[idx][victim] <= bus.axi_rd_data;
        end else if (wr_hit_en) begin
            data_mem[idx][hit_way] <= wdata_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= IDLE;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (bus.wr_req) begin
                    is_wr_q <= 1'b1;
                    addr_q  <= bus.wr_addr;
                    wdata_q <= bus.wr_data;
                end else if (bus.rd_req) begin
                    is_wr_q <= 1'b0;
                    addr_q  <= bus.rd_addr;
                end
            end
            if ((state == LOOKUP) && !is_wr_q && hit) begin
                rd_data_q <= data_mem[idx][hit_way];
            end
            if (fill_en) begin
                valid_q[idx][victim] <= 1'b1;
                rr_q[idx]            <= rr_nxt;
            end
        end
    end

    always_comb begin
        state_nxt            = state;
        bus.rd_valid         = 1'b0;
        bus.rd_data          = '0;
        bus.wr_done          = 1'b0;
        bus.axi_rd_rq        = 1'b0;
        bus.axi_rd_addr      = '0;
        bus.axi_rd_valid_ack = 1'b0;
        bus.axi_wr_rq        = 1'b0;
        bus.axi_wr_addr      = '0;
        bus.axi_wr_data      = '0;
        bus.axi_wr_done_ack  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.wr_req || bus.rd_req) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (is_wr_q)  state_nxt = WR_REQ;
                else if (hit) state_nxt = RESP;
                else          state_nxt = RD_REQ;
            end
            RESP: begin
                bus.rd_valid = 1'b1;
                bus.rd_data  = rd_data_q;
                state_nxt    = IDLE;
            end
            RD_REQ: begin
                bus.axi_rd_rq   = 1'b1;
                bus.axi_rd_addr = line_addr;
                if (bus.axi_rd_rq_ack) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.axi_rd_valid) begin
                    bus.axi_rd_valid_ack = 1'b1;
                    bus.rd_valid         = 1'b1;
                    bus.rd_data          = bus.axi_rd_data;
                    state_nxt            = IDLE;
                end
            end
            WR_REQ: begin
                bus.axi_wr_rq   = 1'b1;
                bus.axi_wr_addr = line_addr;
                bus.axi_wr_data = wdata_q;
                if (bus.axi_wr_rq_ack) state_nxt = WR_WAIT;
            end
            WR_WAIT: begin
                if (bus.axi_wr_done) begin
                    bus.axi_wr_done_ack = 1'b1;
                    bus.wr_done         = 1'b1;
                    state_nxt           = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef CACHE_STATS_EN
    // Only reads resolved in LOOKUP are counted; both counters stick at all-ones.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if ((state == LOOKUP) && !is_wr_q) begin
            if (hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench for set_assoc_cache: directed cases plus randomized reads/writes
// checked against a line-residency model and a word memory that also acts as the AXI slave.
module tb_set_assoc_cache;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int NUM_WAYS = 2;
    localparam int NUM_SETS = 64;
    localparam int IDX_W    = 6;
    localparam int BUDGET   = 60;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    set_assoc_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    set_assoc_cache #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)
    ) dut (
        .i_clk(clk),
        .i_rstn(rstn),
        .bus(bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    int exp_hits    = 0;
    int exp_misses  = 0;

    // Backing memory: written words override an address-derived default pattern.
    logic [31:0] mem [logic [31:0]];
    bit          mv    [NUM_SETS][NUM_WAYS];
    logic [31:0] mline [NUM_SETS][NUM_WAYS];
    int          mrr   [NUM_SETS];

    bit          want_rd, want_wr, rd_ack_nx, wr_ack_nx, rd_pend, wr_pend;
    int          rd_dly, wr_dly;
    logic [31:0] rd_pend_addr;

    logic [31:0] r_rd_data, r_rd_axi_addr, r_wr_axi_addr, r_wr_axi_data;
    int          r_rd_lat, r_rd_axi_cnt, r_wr_axi_cnt;
    bit          r_rd_done, r_wr_done, r_wr_first, r_timeout, r_proto_err;

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(align(a))) return mem[align(a)];
        return align(a) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int s = int'(a[2 +: IDX_W]);
        for (int w = 0; w < NUM_WAYS; w++)
            if (mv[s][w] && (mline[s][w] == align(a))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_fill(input logic [31:0] a);
        int s = int'(a[2 +: IDX_W]);
        int v = -1;
        for (int w = 0; w < NUM_WAYS; w++)
            if (!mv[s][w] && v < 0) v = w;
        if (v < 0) v = mrr[s];
        mrr[s] = (mrr[s] + 1) % NUM_WAYS;
        mv[s][v]    = 1'b1;
        mline[s][v] = align(a);
    endtask

    task automatic model_clear();
        for (int s = 0; s < NUM_SETS; s++) begin
            mrr[s] = 0;
            for (int w = 0; w < NUM_WAYS; w++) mv[s][w] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    function automatic logic any_output_high();
        return |{bus.rd_valid, bus.rd_data, bus.wr_done, bus.axi_rd_rq, bus.axi_rd_addr,
                 bus.axi_rd_valid_ack, bus.axi_wr_rq, bus.axi_wr_addr, bus.axi_wr_data,
                 bus.axi_wr_done_ack};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives core requests and the AXI-slave responses planned at the previous sample.
    task automatic applyStimulus();
        bus.rd_req        = want_rd && !r_rd_done;
        bus.wr_req        = want_wr && !r_wr_done;
        bus.axi_rd_rq_ack = rd_ack_nx;
        bus.axi_wr_rq_ack = wr_ack_nx;
        bus.axi_rd_valid  = 1'b0;
        bus.axi_wr_done   = 1'b0;
        if (rd_pend) begin
            if (rd_dly == 0) begin
                bus.axi_rd_valid = 1'b1;
                bus.axi_rd_data  = mem_rd(rd_pend_addr);
            end else rd_dly--;
        end
        if (wr_pend) begin
            if (wr_dly == 0) bus.axi_wr_done = 1'b1;
            else wr_dly--;
        end
    endtask

    task automatic sample_cycle(input int cyc);
        if (bus.axi_rd_rq && bus.axi_wr_rq) r_proto_err = 1'b1;
        if (bus.rd_valid && bus.wr_done) r_proto_err = 1'b1;
        if (bus.rd_valid) begin
            if (!want_rd || r_rd_done) r_proto_err = 1'b1;
            r_rd_data  = bus.rd_data;
            r_rd_lat   = cyc - 1;
            r_rd_done  = 1'b1;
            r_wr_first = r_wr_done;
        end
        if (bus.wr_done) begin
            if (!want_wr || r_wr_done) r_proto_err = 1'b1;
            r_wr_done = 1'b1;
        end
        if (bus.axi_rd_rq && !rd_ack_nx) begin
            r_rd_axi_cnt++;
            r_rd_axi_addr = bus.axi_rd_addr;
            rd_ack_nx     = 1'b1;
        end else if (rd_ack_nx) begin
            rd_ack_nx    = 1'b0;
            rd_pend      = 1'b1;
            rd_dly       = int'($urandom_range(0, 2));
            rd_pend_addr = r_rd_axi_addr;
        end
        if (bus.axi_rd_valid && bus.axi_rd_valid_ack) rd_pend = 1'b0;
        if (bus.axi_wr_rq && !wr_ack_nx) begin
            r_wr_axi_cnt++;
            r_wr_axi_addr = bus.axi_wr_addr;
            r_wr_axi_data = bus.axi_wr_data;
            wr_ack_nx     = 1'b1;
        end else if (wr_ack_nx) begin
            wr_ack_nx = 1'b0;
            wr_pend   = 1'b1;
            wr_dly    = int'($urandom_range(0, 2));
        end
        if (bus.axi_wr_done && bus.axi_wr_done_ack) wr_pend = 1'b0;
    endtask

    task automatic run_txn(input bit do_rd, input logic [31:0] ra,
                           input bit do_wr, input logic [31:0] wa, input logic [31:0] wd);
        want_rd = do_rd;  want_wr = do_wr;
        rd_ack_nx = 1'b0; wr_ack_nx = 1'b0; rd_pend = 1'b0; wr_pend = 1'b0;
        r_rd_done = 1'b0; r_wr_done = 1'b0; r_wr_first = 1'b0;
        r_timeout = 1'b0; r_proto_err = 1'b0;
        r_rd_axi_cnt = 0; r_wr_axi_cnt = 0; r_rd_lat = -1;
        r_rd_data = '0; r_rd_axi_addr = '0; r_wr_axi_addr = '0; r_wr_axi_data = '0;
        bus.rd_addr = ra; bus.wr_addr = wa; bus.wr_data = wd;
        for (int cyc = 1; cyc <= BUDGET && !((!do_rd || r_rd_done) && (!do_wr || r_wr_done)); cyc++) begin
            @(posedge clk); #1;
            applyStimulus();
            @(negedge clk);
            sample_cycle(cyc);
        end
        if (!((!do_rd || r_rd_done) && (!do_wr || r_wr_done))) r_timeout = 1'b1;
        want_rd = 1'b0; want_wr = 1'b0;
        rd_ack_nx = 1'b0; wr_ack_nx = 1'b0; rd_pend = 1'b0; wr_pend = 1'b0;
        @(posedge clk); #1;
        applyStimulus();
    endtask

    task automatic do_read(input logic [31:0] a);
        bit          h   = model_hit(a);
        logic [31:0] exp = mem_rd(a);
        run_txn(1'b1, a, 1'b0, '0, '0);
        checkOutput($sformatf("rd_timeout@%0h", a), 64'(r_timeout), 64'(0));
        checkOutput($sformatf("rd_data@%0h", a), 64'(r_rd_data), 64'(exp));
        checkOutput($sformatf("rd_axi_cnt@%0h", a), 64'(r_rd_axi_cnt), h ? 64'(0) : 64'(1));
        if (h) checkOutput($sformatf("rd_hit_latency@%0h", a), 64'(r_rd_lat), 64'(2));
        else   checkOutput($sformatf("rd_axi_addr@%0h", a), 64'(r_rd_axi_addr), 64'(align(a)));
        checkOutput($sformatf("rd_protocol@%0h", a), 64'(r_proto_err), 64'(0));
        if (h) exp_hits++;
        else begin
            exp_misses++;
            model_fill(a);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        run_txn(1'b0, '0, 1'b1, a, d);
        checkOutput($sformatf("wr_timeout@%0h", a), 64'(r_timeout), 64'(0));
        checkOutput($sformatf("wr_axi_cnt@%0h", a), 64'(r_wr_axi_cnt), 64'(1));
        checkOutput($sformatf("wr_axi_addr@%0h", a), 64'(r_wr_axi_addr), 64'(align(a)));
        checkOutput($sformatf("wr_axi_data@%0h", a), 64'(r_wr_axi_data), 64'(d));
        checkOutput($sformatf("wr_no_refill@%0h", a), 64'(r_rd_axi_cnt), 64'(0));
        checkOutput($sformatf("wr_protocol@%0h", a), 64'(r_proto_err), 64'(0));
        mem[align(a)] = d;
    endtask

    task automatic clear_inputs();
        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.axi_rd_rq_ack = 1'b0; bus.axi_rd_data = '0; bus.axi_rd_valid = 1'b0;
        bus.axi_wr_rq_ack = 1'b0; bus.axi_wr_done = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs_zero", 64'(any_output_high()), 64'(0));
        rstn = 1'b1;
        model_clear();
    endtask

`ifdef CACHE_STATS_EN
    task automatic check_stats(input string tag);
        checkOutput({tag, "_hit_cnt"}, 64'(hit_cnt), 64'(exp_hits));
        checkOutput({tag, "_miss_cnt"}, 64'(miss_cnt), 64'(exp_misses));
    endtask
`endif

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] rd_exp;
        bit          rd_h;
        clear_inputs();
        model_clear();
        mem[32'h100] = 32'hDEAD_BEEF;
        @(negedge clk);
        do_reset();

        // First touch of 0x100 refills from memory, second access hits without AXI traffic.
        do_read(32'h100);
        checkOutput("first_rd_refill_addr", 64'(r_rd_axi_addr), 64'h100);
        checkOutput("first_rd_data", 64'(r_rd_data), 64'hDEAD_BEEF);
        do_read(32'h100);
        checkOutput("second_rd_no_refill", 64'(r_rd_axi_cnt), 64'(0));
        checkOutput("second_rd_latency", 64'(r_rd_lat), 64'(2));

        // Same-set fill of two lines, then a third line evicts the way-0 line 0x000.
        do_reset();
        do_read(32'h000);
        do_read(32'h100);
        do_read(32'h000);
        checkOutput("set0_line000_hit", 64'(r_rd_axi_cnt), 64'(0));
        do_read(32'h100);
        checkOutput("set0_line100_hit", 64'(r_rd_axi_cnt), 64'(0));
        do_read(32'h200);
        checkOutput("line200_miss", 64'(r_rd_axi_cnt), 64'(1));
        do_read(32'h100);
        checkOutput("line100_survives", 64'(r_rd_axi_cnt), 64'(0));
        do_read(32'h000);
        checkOutput("line000_evicted", 64'(r_rd_axi_cnt), 64'(1));

        do_read(32'h100);
        do_write(32'h100, 32'h1234_5678);
        do_read(32'h100);
        checkOutput("wr_hit_then_rd_hit", 64'(r_rd_axi_cnt), 64'(0));
        checkOutput("wr_hit_then_rd_data", 64'(r_rd_data), 64'h1234_5678);
        do_write(32'h300, 32'h0BAD_F00D);
        do_read(32'h300);
        checkOutput("wr_miss_no_allocate", 64'(r_rd_axi_cnt), 64'(1));
        checkOutput("wr_miss_rd_data", 64'(r_rd_data), 64'h0BAD_F00D);
`ifdef CACHE_STATS_EN
        check_stats("directed");
`endif

        // Simultaneous requests: the write must complete before the read.
        rd_h   = model_hit(32'h000);
        rd_exp = mem_rd(32'h000);
        run_txn(1'b1, 32'h000, 1'b1, 32'h004, 32'hCAFE_F00D);
        checkOutput("both_timeout", 64'(r_timeout), 64'(0));
        checkOutput("both_write_first", 64'(r_wr_first), 64'(1));
        checkOutput("both_rd_data", 64'(r_rd_data), 64'(rd_exp));
        checkOutput("both_wr_axi_data", 64'(r_wr_axi_data), 64'hCAFE_F00D);
        checkOutput("both_protocol", 64'(r_proto_err), 64'(0));
        mem[32'h004] = 32'hCAFE_F00D;
        if (rd_h) exp_hits++;
        else begin
            exp_misses++;
            model_fill(32'h000);
        end

        for (int i = 0; i < 200; i++) begin
            a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 3) do_write(a, $urandom);
            else do_read(a);
        end
`ifdef CACHE_STATS_EN
        check_stats("random");
        do_write(32'h104, 32'h7777_0000);
        check_stats("after_write");
`endif

        // Reset while a refill is being answered: outputs clear at once, stale valid is ignored.
        do_read(32'h500);
        @(posedge clk); #1;
        bus.rd_addr = 32'h000A_BC00;
        bus.rd_req  = 1'b1;
        for (int i = 0; i < 10 && !bus.axi_rd_rq; i++) @(negedge clk);
        checkOutput("rdwait_rq_seen", 64'(bus.axi_rd_rq), 64'(1));
        @(posedge clk); #1;
        bus.axi_rd_rq_ack = 1'b1;
        @(posedge clk); #1;
        bus.axi_rd_rq_ack = 1'b0;
        bus.axi_rd_data   = 32'h1111_2222;
        bus.axi_rd_valid  = 1'b1;
        @(negedge clk);
        checkOutput("rdwait_valid_before_reset", 64'(bus.rd_valid), 64'(1));
        #1 rstn = 1'b0;
        #1;
        checkOutput("rst_in_rdwait_outputs_zero", 64'(any_output_high()), 64'(0));
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_clear();
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("stale_valid_ignored", 64'(bus.axi_rd_valid_ack), 64'(0));
        checkOutput("stale_no_rd_valid", 64'(bus.rd_valid), 64'(0));
        @(posedge clk); #1;
        bus.axi_rd_valid = 1'b0;
        do_read(32'h500);
        checkOutput("post_reset_miss", 64'(r_rd_axi_cnt), 64'(1));
`ifdef CACHE_STATS_EN
        check_stats("post_reset");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
